// File: rtl/ls194_ctrl_pkg.sv
// Shared definitions for the 74LS194 sequencing controller.
//   op_e    : command op codes carried on cmd_op
//   MODE_*  : {S1,S0} mode-pin encodings understood by the 74LS194
//   state_e : controller state
package ls194_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROT  = 2'b11
    } op_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;   // Q0 <= DSr, bits move toward Q3
    localparam logic [1:0] MODE_SHL  = 2'b10;   // Q3 <= DSl, bits move toward Q0
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ls194_seq_ctrl.sv
// Sequencer that drives the mode, serial and parallel pins of an external
// 74LS194 universal shift register to execute LOAD / SHR / SHL / ROT commands.
//
// Ports
//   CP        : clock, all state changes on the rising edge
//   CR        : synchronous active-high reset
//   cmd_valid : command offered
//   cmd_ready : controller can accept (high in IDLE and DONE)
//   cmd_op    : 00 LOAD, 01 SHR, 10 SHL, 11 ROT
//   cmd_dir   : ROT direction, 0 right / 1 left
//   cmd_data  : LOAD value, or serial bits consumed bit0 first
//   cmd_len   : shift count 0..7 (ignored for LOAD)
//   q         : {Q3..Q0} fed back from the 74LS194
//   S0, S1    : 74LS194 mode pins
//   DSr, DSl  : 74LS194 serial inputs
//   D         : 74LS194 parallel data
//   busy      : command in progress
//   done      : one-cycle completion pulse
module ls194_seq_ctrl
    import ls194_ctrl_pkg::*;
(
    input  logic       CP,
    input  logic       CR,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_dir,
    input  logic [3:0] cmd_data,
    input  logic [2:0] cmd_len,
    input  logic [3:0] q,
    output logic       S0,
    output logic       S1,
    output logic       DSr,
    output logic       DSl,
    output logic [3:0] D,
    output logic       busy,
    output logic       done
);

    state_e     state;
    state_e     state_nx;
    op_e        op_r;
    logic       dir_r;
    logic [3:0] ser_r;     // serial bits still to send, current bit in [0]
    logic [2:0] cnt_r;     // RUN cycles remaining after the current one
    logic [3:0] d_r;
    logic [1:0] mode;
    logic       accept;
    logic       skip_run;

    // Rotation only needs the end bits of q; the middle bits are tied off here.
    logic       q_mid_unused;
    assign q_mid_unused = ^q[2:1];

    assign cmd_ready = (state != ST_RUN);
    assign accept    = cmd_valid & cmd_ready;
    // A zero-length shift/rotate has nothing to do and goes straight to DONE.
    assign skip_run  = (op_e'(cmd_op) != OP_LOAD) && (cmd_len == 3'd0);

    // ---------------- state register ----------------
    always_ff @(posedge CP) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (CR) state <= ST_IDLE;
        else    state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned
        // (which would infer a latch).
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nx = skip_run ? ST_DONE : ST_RUN;
                else        state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == 3'd0) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---------------- command datapath ----------------
    always_ff @(posedge CP) begin
        if (CR) begin
            op_r  <= OP_LOAD;
            dir_r <= 1'b0;
            ser_r <= 4'd0;
            cnt_r <= 3'd0;
            d_r   <= 4'd0;
        end else if (accept) begin
            op_r  <= op_e'(cmd_op);
            dir_r <= cmd_dir;
            ser_r <= cmd_data;
            // LOAD runs one cycle; a length of 0 never enters RUN, so the
            // counter is only ever loaded with len-1 when len >= 1 (no wrap).
            cnt_r <= (op_e'(cmd_op) == OP_LOAD || skip_run) ? 3'd0 : cmd_len - 3'd1;
            if (op_e'(cmd_op) == OP_LOAD) d_r <= cmd_data;
        end else if (state == ST_RUN) begin
            // Zero fill means bits beyond cmd_data[3] are sent as 0.
            ser_r <= {1'b0, ser_r[3:1]};
            if (cnt_r != 3'd0) cnt_r <= cnt_r - 3'd1;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        mode = MODE_HOLD;
        DSr  = 1'b0;
        DSl  = 1'b0;
        if (state == ST_RUN) begin
            unique case (op_r)
                OP_LOAD: mode = MODE_LOAD;
                OP_SHR: begin
                    mode = MODE_SHR;
                    DSr  = ser_r[0];
                end
                OP_SHL: begin
                    mode = MODE_SHL;
                    DSl  = ser_r[0];
                end
                OP_ROT: begin
                    // Feed the bit falling off the far end straight back in.
                    if (dir_r) begin
                        mode = MODE_SHL;
                        DSl  = q[0];
                    end else begin
                        mode = MODE_SHR;
                        DSr  = q[3];
                    end
                end
                default: mode = MODE_HOLD;
            endcase
        end
    end

    assign S1   = mode[1];
    assign S0   = mode[0];
    assign D    = d_r;
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ls194_seq_ctrl.sv
// Bench for ls194_seq_ctrl paired with a behavioural 74LS194 (CR_n = ~CR).
// Directed table, hand-written multi-cycle corner cases, and randomized
// commands checked against an arithmetic reference model.
module tb_ls194_seq_ctrl;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_data = 4'd0;
    logic [2:0] cmd_len = 3'd0;
    logic [3:0] q;
    logic       cmd_ready, S0, S1, DSr, DSl, busy, done;
    logic [3:0] D;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] mq = 4'd0;   // reference contents of the downstream register

    always #5 CP = ~CP;

    ls194_seq_ctrl dut (
        .CP(CP), .CR(CR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .q(q), .S0(S0), .S1(S1), .DSr(DSr), .DSl(DSl), .D(D),
        .busy(busy), .done(done)
    );

    // Downstream 74LS194: asynchronous clear, mode-selected update.
    logic cr_n;
    assign cr_n = ~CR;
    always @(posedge CP or negedge cr_n) begin
        if (!cr_n) q <= 4'd0;
        else begin
            case ({S1, S0})
                2'b01:   q <= {q[2:0], DSr};
                2'b10:   q <= {DSl, q[3:1]};
                2'b11:   q <= D;
                default: q <= q;
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_mode(input logic [1:0] op, input logic dir);
        case (op)
            2'd0:    return 3;
            2'd1:    return 1;
            2'd2:    return 2;
            default: return dir ? 2 : 1;
        endcase
    endfunction

    function automatic int ref_bit(input logic [3:0] qv, input logic [1:0] op,
                                   input logic dir, input logic [3:0] data, input int k);
        int v;
        v = int'(qv);
        if (op == 2'd3) return dir ? (v % 2) : (v / 8);
        if (k < 4) return int'(data[k]);
        return 0;
    endfunction

    function automatic logic [3:0] ref_step(input logic [3:0] qv, input logic [1:0] op,
                                            input logic dir, input logic [3:0] data, input int k);
        int v, b;
        v = int'(qv);
        b = ref_bit(qv, op, dir, data, k);
        case (op)
            2'd0:    return data;
            2'd1:    return 4'((v * 2 + b) % 16);
            2'd2:    return 4'(v / 2 + b * 8);
            default: return dir ? 4'(v / 2 + (v % 2) * 8) : 4'((v * 2 + v / 8) % 16);
        endcase
    endfunction

    // Issue one command and follow it to completion.
    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] data,
                           input logic [2:0] len, input logic [3:0] exp_final, input bit junk);
        int ncyc, k, w, m;
        ncyc = (op == 2'd0) ? 1 : int'(len);
        m    = ref_mode(op, dir);
        @(negedge CP);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge CP);
            w++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_data = data; cmd_len = len;
        @(negedge CP);
        cmd_valid = 1'b0;
        k = 0;
        while (busy && k < 12) begin
            check("run_mode", int'({S1, S0}), m);
            check("run_ready", int'(cmd_ready), 0);
            if (m == 3) begin
                check("run_D", int'(D), int'(data));
            end else if (m == 1) begin
                check("run_DSr", int'(DSr), ref_bit(mq, op, dir, data, k));
                check("run_DSl_idle", int'(DSl), 0);
            end else begin
                check("run_DSl", int'(DSl), ref_bit(mq, op, dir, data, k));
                check("run_DSr_idle", int'(DSr), 0);
            end
            // Commands offered while busy must be ignored.
            if (junk && k < ncyc - 1) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_data  = 4'($urandom);
                cmd_len   = 3'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            mq = ref_step(mq, op, dir, data, k);
            @(negedge CP);
            check("q_step", int'(q), int'(mq));
            k++;
        end
        cmd_valid = 1'b0;
        check("run_cycles", k, ncyc);
        check("done_pulse", int'(done), 1);
        check("done_mode", int'({S1, S0}), 0);
        check("done_serial", int'({DSr, DSl}), 0);
        check("done_busy_ready", int'({busy, cmd_ready}), 1);
        check("q_final", int'(q), int'(exp_final));
        @(negedge CP);
        check("after_done_idle", int'({done, busy}), 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       dir;
        logic [3:0] data;
        logic [2:0] len;
        logic [3:0] exp_q;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [3:0] qf;
        logic [1:0] rop;
        logic       rdir;
        logic [3:0] rdata;
        logic [2:0] rlen;

        tbl[0]  = '{2'd0, 1'b0, 4'b1100, 3'd0, 4'b1100};  // LOAD 1100
        tbl[1]  = '{2'd0, 1'b0, 4'b0000, 3'd0, 4'b0000};  // LOAD 0000
        tbl[2]  = '{2'd1, 1'b0, 4'b1011, 3'd4, 4'b1101};  // SHR len4
        tbl[3]  = '{2'd0, 1'b0, 4'b0000, 3'd0, 4'b0000};  // LOAD 0000
        tbl[4]  = '{2'd2, 1'b0, 4'b0001, 3'd2, 4'b0100};  // SHL len2 data 01
        tbl[5]  = '{2'd0, 1'b0, 4'b0001, 3'd0, 4'b0001};  // LOAD 0001
        tbl[6]  = '{2'd3, 1'b0, 4'b0000, 3'd3, 4'b1000};  // ROT right len3
        tbl[7]  = '{2'd3, 1'b1, 4'b0000, 3'd1, 4'b0100};  // ROT left len1
        tbl[8]  = '{2'd1, 1'b0, 4'b1111, 3'd7, 4'b1000};  // SHR len7, bits 4..6 are 0
        tbl[9]  = '{2'd2, 1'b0, 4'b1111, 3'd0, 4'b1000};  // SHL len0, no RUN
        tbl[10] = '{2'd3, 1'b1, 4'b0000, 3'd7, 4'b0001};  // ROT left len7

        // Reset state.
        CR = 1'b1;
        repeat (2) @(posedge CP);
        @(negedge CP);
        check("rst_mode", int'({S1, S0}), 0);
        check("rst_serial", int'({DSr, DSl}), 0);
        check("rst_D", int'(D), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        check("rst_ready", int'(cmd_ready), 1);
        CR = 1'b0;
        mq = 4'd0;

        for (int i = 0; i < 11; i++)
            run_cmd(tbl[i].op, tbl[i].dir, tbl[i].data, tbl[i].len, tbl[i].exp_q, 1'b0);

        // Reset mid-RUN after two shifts: aborts with no done pulse.
        @(negedge CP);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'b1010; cmd_len = 3'd4;
        @(negedge CP);
        cmd_valid = 1'b0;
        check("abort_busy_start", int'(busy), 1);
        repeat (2) @(negedge CP);
        check("abort_still_busy", int'(busy), 1);
        CR = 1'b1;
        @(negedge CP);
        check("abort_no_done", int'(done), 0);
        check("abort_mode", int'({S1, S0}), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_D", int'(D), 0);
        CR = 1'b0;
        mq = 4'd0;
        @(negedge CP);
        check("abort_no_late_done", int'({done, busy}), 0);

        // Reset wins over a simultaneous handshake.
        CR = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'b0101;
        @(negedge CP);
        CR = 1'b0;
        cmd_valid = 1'b0;
        check("rst_prio_busy", int'(busy), 0);
        check("rst_prio_D", int'(D), 0);
        @(negedge CP);
        check("rst_prio_not_taken", int'({busy, done}), 0);

        // len=0 then a back-to-back command accepted in the DONE cycle.
        run_cmd(2'd0, 1'b0, 4'b0110, 3'd0, 4'b0110, 1'b0);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'b1111; cmd_len = 3'd0;
        @(negedge CP);
        check("len0_done", int'(done), 1);
        check("len0_busy", int'(busy), 0);
        check("len0_q", int'(q), 6);
        check("len0_ready", int'(cmd_ready), 1);
        cmd_op = 2'd0; cmd_data = 4'b1001;
        @(negedge CP);
        cmd_valid = 1'b0;
        check("b2b_busy", int'(busy), 1);
        check("b2b_mode", int'({S1, S0}), 3);
        check("b2b_D", int'(D), 9);
        @(negedge CP);
        check("b2b_done", int'(done), 1);
        check("b2b_q", int'(q), 9);
        mq = 4'b1001;

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop   = 2'($urandom_range(0, 3));
            rdir  = 1'($urandom_range(0, 1));
            rdata = 4'($urandom);
            rlen  = 3'($urandom);
            qf = mq;
            if (rop == 2'd0) qf = rdata;
            else for (int k = 0; k < int'(rlen); k++) qf = ref_step(qf, rop, rdir, rdata, k);
            repeat ($urandom_range(0, 2)) @(negedge CP);
            run_cmd(rop, rdir, rdata, rlen, qf, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ls194_seq_ctrl.md
LS194_SEQ_CTRL -- requirements
Module: ls194_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CP (clock) and CR (reset).
REQ-002 CP  in  1  clock; all state updates on the rising edge.
REQ-003 CR  in  1  synchronous active-high reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  block can accept; a command transfers on an edge with cmd_valid&cmd_ready.
REQ-006 cmd_op  in  2  00 LOAD, 01 SHR (serial in at DSr), 10 SHL (serial in at DSl), 11 ROT.
REQ-007 cmd_dir  in  1  ROT only: 0 rotate right, 1 rotate left.
REQ-008 cmd_data  in  4  LOAD value, or serial bits consumed bit0 first.
REQ-009 cmd_len  in  3  shift count 0..7; ignored for LOAD.
REQ-010 q  in  4  {Q3,Q2,Q1,Q0} fed back from the downstream reg74ls194.
REQ-011 S0, S1, DSr, DSl  out  1 each  mode and serial pins of reg74ls194.
REQ-012 D  out  4  parallel data to D3..D0.
REQ-013 busy  out  1  command in progress.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 Mode encoding {S1,S0}: 00 hold, 01 shift right (Q0<=DSr), 10 shift left (Q3<=DSl), 11 load.
REQ-016 States: IDLE (cmd_ready=1), RUN (cmd_ready=0, busy=1), DONE (done=1, cmd_ready=1).
REQ-017 On acceptance in IDLE or DONE: latch op/dir/data/len, load counter, enter RUN; mode pins show the command mode from the next cycle.
REQ-018 LOAD: RUN lasts exactly one cycle with {S1,S0}=11 and D=cmd_data; then DONE.
REQ-019 SHR/SHL: RUN lasts exactly cmd_len cycles; during the k-th cycle (k=0..len-1) the active serial pin = cmd_data[k] for k<4, else 0.
REQ-020 ROT: RUN lasts cmd_len cycles; right uses {S1,S0}=01 with DSr=q[3], left uses 10 with DSl=q[0], combinationally from q.
REQ-021 cmd_len=0 for SHR/SHL/ROT: no RUN cycle; go directly to DONE with mode 00.
REQ-022 Outside RUN, {S1,S0}=00; the inactive serial pin is 0; D holds its last value.
REQ-023 DONE lasts one cycle; returns to IDLE unless a new command is accepted in it.
REQ-024 cmd_valid while not ready SHALL be ignored; the command is not consumed.
REQ-025 Counter is 3 bits, loaded with len-1, and RUN exits when it reaches 0; no wrap-around.

Reset
REQ-026 On CR: state IDLE, {S1,S0}=00, DSr=DSl=0, D=0000, busy=0, done=0, cmd_ready=1.
REQ-027 CR mid-RUN SHALL abort: no done pulse, mode returns to 00 after that edge; the downstream register is not cleared by this block.
REQ-028 CR takes priority over a simultaneous command handshake.

Structure
REQ-029 Package ls194_ctrl_pkg SHALL hold the op codes, the {S1,S0} mode constants, and the state enum.
REQ-030 The block SHALL be a single module with no sub-modules; the bench pairs it with reg74ls194 (CR_n = ~CR).

Verification
REQ-031 Reset, then LOAD data=1100 -> mode 11 for one cycle, q=1100, done pulse, mode 00.
REQ-032 From q=0000, SHR len=4 data=1011 -> DSr sequence 1,1,0,1; final q=1101; busy exactly 4 cycles.
REQ-033 From q=0000, SHL len=2 data=01 -> DSl sequence 1,0; final q=0100.
REQ-034 From q=0001, ROT right len=3 -> q 0010, 0100, 1000; then ROT left len=1 -> q=0100.
REQ-035 SHR len=4 with CR asserted after 2 shifts -> no done pulse, mode 00, busy=0, cmd_ready=1.
REQ-036 SHR len=0 -> done the next cycle with q unchanged; a second command held valid is accepted in the DONE cycle, with no IDLE gap.
